// File: rtl/bus_copier_pkg.sv
// Shared definitions for the bus copier: state encoding, default widths
// and the per-word address step.
package bus_copier_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 32;

  // Byte distance between consecutive words on the bus.
  localparam int ADDR_INC = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copier_state_t;

endpackage

// File: rtl/bus_copier.sv
// Bus copier: moves a block of words from a source to a destination
// address using alternating single-cycle read and write strobes.
// Each word costs exactly two cycles (one READ, one WRITE), and a
// single DONE cycle reports completion and whether it was aborted.
module bus_copier
  import bus_copier_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_bus,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              bus_read,
  output logic              bus_write
);

  copier_state_t     state_q;
  copier_state_t     state_d;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              aborted_q;

  // State register; reset drops straight back to IDLE so any copy in flight is abandoned.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer bookkeeping: latch the request, capture read data, step addresses after each write.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            cnt_q     <= count;
            aborted_q <= 1'b0;
          end
        end
        ST_READ: begin
          data_q <= bus_data_i;
          if (abort) begin
            aborted_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          cnt_q <= cnt_q - 8'd1;
          src_q <= src_q + ADDR_W'(ADDR_INC);
          dst_q <= dst_q + ADDR_W'(ADDR_INC);
          if (abort) begin
            aborted_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state selection and bus/status outputs, all decoded from the current state.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_address = '0;
    bus_data_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count != 8'd0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        busy        = 1'b1;
        bus_read    = 1'b1;
        bus_address = src_q;
        state_d     = abort ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        busy        = 1'b1;
        bus_write   = 1'b1;
        bus_address = dst_q;
        bus_data_o  = data_q;
        state_d     = (abort || (cnt_q == 8'd1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        aborted = aborted_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_copier.sv
// Self-checking bench for bus_copier: a bench-side memory answers the
// bus, and a word-level reference model predicts every strobe, the
// completion cycle, the abort flag and the final memory image.
module tb_bus_copier;

  logic        clk_bus;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  bus_address;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_read;
  logic        bus_write;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] busMem [64];
  logic [31:0] refMem [64];

  int overlapErr   = 0;
  int dataLowErr   = 0;
  int abortFlagErr = 0;
  int idleStrobe   = 0;

  bus_copier dut (
    .clk_bus     (clk_bus),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .bus_address (bus_address),
    .bus_data_o  (bus_data_o),
    .bus_data_i  (bus_data_i),
    .bus_read    (bus_read),
    .bus_write   (bus_write)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  assign bus_data_i = bus_read ? busMem[bus_address[7:2]] : 32'h0;

  // Bench memory takes each write strobe at the clock edge.
  always @(posedge clk_bus) begin
    if (bus_write) busMem[bus_address[7:2]] <= bus_data_o;
  end

  // Continuous invariants: strobe exclusivity, quiet data bus, aborted only with done.
  always @(negedge clk_bus) begin
    if (bus_read && bus_write) overlapErr++;
    if (!bus_write && bus_data_o != 32'h0) dataLowErr++;
    if (!done && aborted) abortFlagErr++;
    if ((!busy || done) && (bus_read || bus_write)) idleStrobe++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One copy request. abortAt: cycle (1 = first cycle after acceptance) at which abort is
  // held high, 0 for none. restartAt: cycle at which a stray start is pulsed, 0 for none.
  task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] cnt,
                               input int abortAt, input int restartAt, input bit abortWithStart);
    logic [47:0] expQ[$];
    logic [47:0] gotQ[$];
    logic [7:0]  s;
    logic [7:0]  d;
    logic [31:0] v;
    int          n;
    int          expDone;
    bit          expAb;
    int          doneAt;
    bit          abSeen;
    int          busyCycles;
    n = int'(cnt);
    s = src;
    d = dst;
    expAb = (abortAt >= 1) && (abortAt <= 2 * n);
    expDone = expAb ? abortAt + 1 : 2 * n + 1;
    for (int i = 0; i < n; i++) begin
      v = refMem[s[7:2]];
      expQ.push_back({8'h52, s, v});
      if (abortAt == 2 * i + 1) break;
      expQ.push_back({8'h57, d, v});
      refMem[d[7:2]] = v;
      if (abortAt == 2 * i + 2) break;
      s = s + 8'd4;
      d = d + 8'd4;
    end

    @(posedge clk_bus); #1;
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; abort = abortWithStart;
    src_addr = src; dst_addr = dst; count = cnt;
    @(posedge clk_bus); #1;
    start = 1'b0; abort = 1'b0;
    src_addr = 8'($urandom); dst_addr = 8'($urandom); count = 8'($urandom);
    doneAt = 0; abSeen = 1'b0; busyCycles = 0;
    for (int c = 1; c <= 600 && doneAt == 0; c++) begin
      abort = (c == abortAt);
      start = (c == restartAt);
      if (start) begin
        src_addr = 8'($urandom) & 8'hFC; dst_addr = 8'($urandom) & 8'hFC; count = 8'($urandom_range(1, 9));
      end
      @(negedge clk_bus);
      if (busy) busyCycles++;
      if (bus_read) gotQ.push_back({8'h52, bus_address, bus_data_i});
      if (bus_write) gotQ.push_back({8'h57, bus_address, bus_data_o});
      if (done) begin
        doneAt = c;
        abSeen = aborted;
      end
      @(posedge clk_bus); #1;
    end
    abort = 1'b0; start = 1'b0;
    if (doneAt == 0) checkOutput("done_timeout", 64'd1, 64'd0);
    checkOutput("done_cycle", 64'(doneAt), 64'(expDone));
    checkOutput("aborted", {63'd0, abSeen}, {63'd0, expAb});
    checkOutput("busy_cycles", 64'(busyCycles), 64'(expDone));
    checkOutput("strobe_count", 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("strobe%0d", i), {16'd0, gotQ[i]}, {16'd0, expQ[i]});
    @(negedge clk_bus);
    checkOutput("after_done_idle", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int memDiff;
    int doneInReset;
    logic [7:0] rs;
    logic [7:0] rd;
    logic [7:0] rc;
    int ra;
    int rr;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; count = 8'h00;
    for (int i = 0; i < 64; i++) begin
      busMem[i] = $urandom;
      refMem[i] = busMem[i];
    end
    #12;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_aborted", {63'd0, aborted}, 64'd0);
    checkOutput("rst_strobes", {62'd0, bus_read, bus_write}, 64'd0);
    checkOutput("rst_address", {56'd0, bus_address}, 64'd0);
    checkOutput("rst_data_o", {32'd0, bus_data_o}, 64'd0);
    @(negedge clk_bus); rst_n = 1'b1;

    $display("[TB] basic three-word copy");
    applyStimulus(8'h10, 8'h40, 8'd3, 0, 0, 1'b0);
    $display("[TB] zero-length copy");
    applyStimulus(8'h20, 8'h60, 8'd0, 0, 0, 1'b0);
    $display("[TB] source wraps past FC");
    applyStimulus(8'hF8, 8'h80, 8'd3, 0, 0, 1'b0);
    $display("[TB] abort during second read");
    applyStimulus(8'h30, 8'hC0, 8'd4, 3, 0, 1'b0);
    $display("[TB] abort during last write");
    applyStimulus(8'h50, 8'hD0, 8'd2, 4, 0, 1'b0);
    $display("[TB] stray start while busy");
    applyStimulus(8'h04, 8'h90, 8'd3, 0, 2, 1'b0);
    $display("[TB] start and abort together in idle");
    applyStimulus(8'h08, 8'hA8, 8'd2, 0, 0, 1'b1);
    $display("[TB] abort during done is ignored");
    applyStimulus(8'h0C, 8'hB0, 8'd2, 5, 0, 1'b0);

    $display("[TB] reset during write of a five-word copy");
    @(posedge clk_bus); #1;
    start = 1'b1; src_addr = 8'h20; dst_addr = 8'hE0; count = 8'd5;
    @(posedge clk_bus); #1; start = 1'b0;
    @(posedge clk_bus); #1;
    @(posedge clk_bus); #1;
    @(posedge clk_bus); #1;
    checkOutput("pre_reset_write", {63'd0, bus_write}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", {bus_data_o, 11'd0, busy, done, aborted, bus_read, bus_write, bus_address}, 64'd0);
    refMem[8'hE0 >> 2] = refMem[8'h20 >> 2];
    doneInReset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_bus);
      if (done) doneInReset++;
    end
    rst_n = 1'b1;
    @(negedge clk_bus);
    if (done) doneInReset++;
    checkOutput("no_done_in_reset", 64'(doneInReset), 64'd0);
    checkOutput("idle_after_release", {63'd0, busy}, 64'd0);
    applyStimulus(8'h24, 8'hE8, 8'd3, 0, 0, 1'b0);

    $display("[TB] randomized copies");
    for (int t = 0; t < 25; t++) begin
      rs = 8'($urandom) & 8'hFC;
      rd = 8'($urandom) & 8'hFC;
      rc = 8'($urandom_range(0, 12));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * int'(rc) + 1)) : 0;
      rr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * int'(rc) + 1)) : 0;
      applyStimulus(rs, rd, rc, ra, rr, 1'($urandom_range(0, 1)));
    end

    memDiff = 0;
    for (int i = 0; i < 64; i++)
      if (busMem[i] !== refMem[i]) memDiff++;
    checkOutput("final_memory", 64'(memDiff), 64'd0);
    checkOutput("strobe_overlap", 64'(overlapErr), 64'd0);
    checkOutput("data_o_idle_zero", 64'(dataLowErr), 64'd0);
    checkOutput("aborted_without_done", 64'(abortFlagErr), 64'd0);
    checkOutput("strobe_outside_copy", 64'(idleStrobe), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
